clk_cnt_sweep_ctrl: RTL and testbench

Sequencer for the 4-bit full-adder ripple up/down counter. The counter steps every clock: +1 when up=1, -1 when up=0, and it has no hold. This block drives the counter's direction (up) and its active-low reset. It sweeps the counter 0 -> HI -> 0 a programmed number of times, then parks it cleared at 0. It sits beside the counter on the same clk and reports busy, done, a sweep count and a bad-program error.

---
 rtl/clk_cnt_sweep_ctrl.sv | 138 +++++++++++++
 tb/tb_clk_cnt_sweep_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/clk_cnt_sweep_ctrl.sv
// Sweep sequencer for a free-running up/down counter: drives direction and the
// counter's active-low reset to run 0 -> HI -> 0 a programmed number of times.
module clk_cnt_sweep_ctrl #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned SWW   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic [WIDTH-1:0] hi_in,
  input  logic [SWW-1:0]   sweeps_in,
  input  logic [WIDTH-1:0] cnt,
  output logic             up,
  output logic             cnt_rst_n,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [SWW-1:0]   sweep_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [SWW-1:0]   sweeps_q, sweeps_d;
  logic [SWW-1:0]   sweep_cnt_q, sweep_cnt_d;
  logic             stop_pend_q, stop_pend_d;
  logic             cnt_rst_n_q, cnt_rst_n_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic             sweep_end;
  logic             last;
  logic [SWW:0]     sweep_next;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      hi_q        <= '0;
      sweeps_q    <= '0;
      sweep_cnt_q <= '0;
      stop_pend_q <= 1'b0;
      cnt_rst_n_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      hi_q        <= hi_d;
      sweeps_q    <= sweeps_d;
      sweep_cnt_q <= sweep_cnt_d;
      stop_pend_q <= stop_pend_d;
      cnt_rst_n_q <= cnt_rst_n_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  // Direction is combinational so the counter turns around on the peak edge itself.
  always_comb begin
    up = 1'b1;
    case (state_q)
      UP:      up = (cnt != hi_q);
      DOWN:    up = 1'b0;
      default: up = 1'b1;
    endcase
  end

  // Counter at 1 and stepping down means it lands on 0 this edge.
  assign sweep_end  = (state_q != IDLE) && !up && (cnt == WIDTH'(1));
  assign sweep_next = {1'b0, sweep_cnt_q} + (SWW+1)'(1);
  assign last       = stop_pend_q || stop ||
                      ((sweeps_q != '0) && (sweep_next == {1'b0, sweeps_q}));

  always_comb begin
    state_d     = state_q;
    hi_d        = hi_q;
    sweeps_d    = sweeps_q;
    sweep_cnt_d = sweep_cnt_q;
    stop_pend_d = stop_pend_q;
    cnt_rst_n_d = cnt_rst_n_q;
    done_d      = 1'b0;
    err_d       = 1'b0;

    if ((state_q != IDLE) && stop) begin
      stop_pend_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        cnt_rst_n_d = 1'b0;
        if (start) begin
          if (hi_in != '0) begin
            hi_d        = hi_in;
            sweeps_d    = sweeps_in;
            sweep_cnt_d = '0;
            stop_pend_d = 1'b0;
            cnt_rst_n_d = 1'b1;
            state_d     = UP;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      UP, DOWN: begin
        if (sweep_end) begin
          if (sweep_cnt_q != '1) begin
            sweep_cnt_d = sweep_next[SWW-1:0];
          end
          if (last) begin
            state_d     = IDLE;
            cnt_rst_n_d = 1'b0;
            done_d      = 1'b1;
          end else begin
            state_d = UP;
          end
        end else if ((state_q == UP) && (cnt == hi_q)) begin
          state_d = DOWN;
        end
      end
      default: begin
        state_d     = IDLE;
        cnt_rst_n_d = 1'b0;
      end
    endcase
  end

  assign busy      = (state_q != IDLE);
  assign cnt_rst_n = cnt_rst_n_q;
  assign done      = done_q;
  assign err       = err_q;
  assign sweep_cnt = sweep_cnt_q;

endmodule

// File: tb/tb_clk_cnt_sweep_ctrl.sv
// Bench for clk_cnt_sweep_ctrl: attaches a behavioural up/down counter with
// async active-low reset and checks each run against an arithmetic sweep model.
module tb_clk_cnt_sweep_ctrl;

  localparam int W = 4;
  localparam int S = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         stop;
  logic [W-1:0] hi_in;
  logic [S-1:0] sweeps_in;
  logic [W-1:0] cnt;
  logic         up;
  logic         cnt_rst_n;
  logic         busy;
  logic         done;
  logic         err;
  logic [S-1:0] sweep_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // The external counter: steps every edge, no hold, cleared asynchronously.
  always_ff @(posedge clk or negedge cnt_rst_n) begin
    if (!cnt_rst_n) cnt <= '0;
    else if (up)    cnt <= cnt + 1'b1;
    else            cnt <= cnt - 1'b1;
  end

  clk_cnt_sweep_ctrl #(.WIDTH(W), .SWW(S)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .stop      (stop),
    .hi_in     (hi_in),
    .sweeps_in (sweeps_in),
    .cnt       (cnt),
    .up        (up),
    .cnt_rst_n (cnt_rst_n),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .sweep_cnt (sweep_cnt)
  );

  // Runs one sweep program, expecting the triangle wave cnt(k) = phase folded at hi.
  // stop_at/ign_at < 0 disable the stop pulse / the ignored mid-run start.
  task automatic run_sweep(input string name, input int hi, input int sw,
                           input int stop_at, input int ign_at, input bit chain);
    int per, nsw, total, phase, ns;
    logic [W-1:0] e_cnt;
    logic         e_up;
    logic [S-1:0] e_sc;
    per = 2 * hi;
    nsw = sw;
    if (stop_at >= 0) begin
      ns = stop_at / per + 1;
      if (sw == 0 || ns < sw) nsw = ns;
    end
    total = per * nsw;
    hi_in = W'(hi);
    sweeps_in = S'(sw);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < total; k++) begin
      phase = k % per;
      e_cnt = W'((phase <= hi) ? phase : per - phase);
      e_up  = (phase < hi);
      e_sc  = S'(k / per);
      tests++;
      if ({busy, cnt_rst_n, up, cnt, sweep_cnt, done} !== {1'b1, 1'b1, e_up, e_cnt, e_sc, 1'b0}) begin
        fails++;
        $display("FAIL %s cycle %0d: busy=%b rst_n=%b up=%b cnt=%0d sweep_cnt=%0d done=%b, expected busy=1 rst_n=1 up=%b cnt=%0d sweep_cnt=%0d done=0",
                 name, k, busy, cnt_rst_n, up, cnt, sweep_cnt, done, e_up, e_cnt, e_sc);
      end
      stop = (k == stop_at);
      if (k == ign_at) begin
        start = 1'b1;
        hi_in = 4'd7;
        sweeps_in = 8'd9;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    stop = 1'b0;
    start = 1'b0;
    tests++;
    if ({busy, done, cnt_rst_n, cnt, sweep_cnt} !== {1'b0, 1'b1, 1'b0, W'(0), S'(nsw)}) begin
      fails++;
      $display("FAIL %s end: busy=%b done=%b rst_n=%b cnt=%0d sweep_cnt=%0d, expected busy=0 done=1 rst_n=0 cnt=0 sweep_cnt=%0d",
               name, busy, done, cnt_rst_n, cnt, sweep_cnt, nsw);
    end
    if (!chain) begin
      @(negedge clk);
      tests++;
      if ({busy, done, cnt, sweep_cnt} !== {1'b0, 1'b0, W'(0), S'(nsw)}) begin
        fails++;
        $display("FAIL %s idle: busy=%b done=%b cnt=%0d sweep_cnt=%0d, expected busy=0 done=0 cnt=0 sweep_cnt=%0d",
                 name, busy, done, cnt, sweep_cnt, nsw);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    start = 1'b0;
    stop = 1'b0;
    hi_in = '0;
    sweeps_in = '0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    tests++;
    if ({busy, done, err, cnt_rst_n, up, cnt, sweep_cnt} !== {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, W'(0), S'(0)}) begin
      fails++;
      $display("FAIL reset: busy=%b done=%b err=%b rst_n=%b up=%b cnt=%0d sweep_cnt=%0d, expected 0 0 0 0 1 0 0",
               busy, done, err, cnt_rst_n, up, cnt, sweep_cnt);
    end
  endtask

  task automatic test_err();
    hi_in = '0;
    sweeps_in = 8'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    tests++;
    if ({err, busy, cnt_rst_n, cnt} !== {1'b1, 1'b0, 1'b0, W'(0)}) begin
      fails++;
      $display("FAIL err_pulse: err=%b busy=%b rst_n=%b cnt=%0d, expected err=1 busy=0 rst_n=0 cnt=0",
               err, busy, cnt_rst_n, cnt);
    end
    @(negedge clk);
    tests++;
    if ({err, busy, cnt_rst_n, cnt} !== {1'b0, 1'b0, 1'b0, W'(0)}) begin
      fails++;
      $display("FAIL err_clear: err=%b busy=%b rst_n=%b cnt=%0d, expected all 0", err, busy, cnt_rst_n, cnt);
    end
  endtask

  task automatic test_stop_idle();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    tests++;
    if ({busy, done, cnt} !== {1'b0, 1'b0, W'(0)}) begin
      fails++;
      $display("FAIL stop_idle: busy=%b done=%b cnt=%0d, expected 0 0 0", busy, done, cnt);
    end
    run_sweep("after_idle_stop", 2, 2, -1, -1, 1'b0);
  endtask

  task automatic test_reset_midrun();
    hi_in = 4'd5;
    sweeps_in = 8'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    tests++;
    if ({busy, up, cnt} !== {1'b1, 1'b0, 4'd3}) begin
      fails++;
      $display("FAIL midrun_pre: busy=%b up=%b cnt=%0d, expected busy=1 up=0 cnt=3", busy, up, cnt);
    end
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    tests++;
    if ({busy, cnt_rst_n, cnt, sweep_cnt, done} !== {1'b0, 1'b0, W'(0), S'(0), 1'b0}) begin
      fails++;
      $display("FAIL midrun_reset: busy=%b rst_n=%b cnt=%0d sweep_cnt=%0d done=%b, expected all 0",
               busy, cnt_rst_n, cnt, sweep_cnt, done);
    end
    @(negedge clk);
    tests++;
    if ({busy, cnt, done} !== {1'b0, W'(0), 1'b0}) begin
      fails++;
      $display("FAIL midrun_after: busy=%b cnt=%0d done=%b, expected 0 0 0", busy, cnt, done);
    end
  endtask

  task automatic test_random();
    int hi, sw, per, st;
    for (int i = 0; i < 8; i++) begin
      hi = int'($urandom_range(15, 1));
      sw = int'($urandom_range(4, 0));
      per = 2 * hi;
      st = -1;
      if (sw == 0)                       st = int'($urandom_range(3 * per - 1, 0));
      else if ($urandom_range(1, 0) == 1) st = int'($urandom_range(per * sw - 1, 0));
      run_sweep("random", hi, sw, st, -1, 1'b0);
    end
  endtask

  task automatic test_back_to_back();
    run_sweep("b2b_first", 2, 1, -1, -1, 1'b1);
    run_sweep("b2b_second", 4, 2, -1, -1, 1'b0);
  endtask

  initial begin
    test_reset();
    run_sweep("basic_hi3", 3, 2, -1, -1, 1'b0);
    run_sweep("hi1_toggle", 1, 3, -1, -1, 1'b0);
    run_sweep("continuous_stop", 5, 0, 14, -1, 1'b0);
    run_sweep("stop_at_sweep_end", 3, 0, 5, -1, 1'b0);
    test_err();
    test_reset_midrun();
    run_sweep("ignore_midrun", 2, 1, -1, 1, 1'b0);
    run_sweep("peak_max", 15, 1, -1, -1, 1'b0);
    test_stop_idle();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
